// File: rtl/ysyx_24110015_mem_responder.sv
// ysyx_24110015_mem_responder
//   Memory-side responder for the core's fetch/load-store bus. It is an
//   AXI4-Lite subset slave (AR/R and AW/W/B) backed by an internal word array.
//   Only one transaction is outstanding at a time, and each transaction has a
//   programmable latency.
//
// Ports
//   clk                       clock; all state changes on the rising edge
//   rst                       synchronous reset, active-low
//   araddr/arvalid/arready    read address channel
//   rdata/rresp/rvalid/rready read data channel (rresp: 00 OKAY, 11 DECERR)
//   awaddr/awvalid/awready    write address channel
//   wdata/wstrb/wvalid/wready write data channel (AW and W are taken together)
//   bresp/bvalid/bready       write response channel (bresp: 00 OKAY, 11 DECERR)
//
// state   | meaning
// IDLE    | ready for a request; a read wins over a simultaneous write
// RD_WAIT | read accepted, latency timer running
// RD_RESP | rvalid high, holding data until rready
// WR_WAIT | write accepted, latency timer running
// WR_RESP | bvalid high, holding response until bready
module ysyx_24110015_mem_responder #(
  parameter logic [31:0] BASE   = 32'h8000_0000,
  parameter int          DEPTH  = 4096,
  parameter int          RD_LAT = 2,
  parameter int          WR_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int          IDX_W   = $clog2(DEPTH);
  localparam int          MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int          TW      = $clog2(MAX_LAT + 1);
  localparam logic [32:0] LIMIT   = {1'b0, BASE} + (33'(DEPTH) << 2);

  typedef enum logic [2:0] {IDLE, RD_WAIT, RD_RESP, WR_WAIT, WR_RESP} state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [3:0]    wstrb_q;
  logic [31:0]   mem [DEPTH];

  logic          rd_accept;
  logic          wr_accept;
  logic          rd_fire;
  logic          wr_fire;
  logic [31:0]   addr_eff;
  logic [31:0]   wdata_eff;
  logic [3:0]    wstrb_eff;
  logic [31:0]   offset;
  logic          in_range;
  logic [IDX_W-1:0] idx;
  logic          unused_bits;

  assign arready   = (state == IDLE);
  assign rd_accept = (state == IDLE) && arvalid;
  assign wr_accept = (state == IDLE) && awvalid && wvalid && !arvalid;
  assign awready   = wr_accept;
  assign wready    = wr_accept;

  // The timer is loaded with LAT-1 at accept and counts down. The response
  // registers at the edge where it reaches 1, so valid rises LAT cycles after
  // accept. LAT==1 responds directly at the accept edge.
  assign rd_fire = (RD_LAT == 1) ? rd_accept : ((state == RD_WAIT) && (timer == TW'(1)));
  assign wr_fire = (WR_LAT == 1) ? wr_accept : ((state == WR_WAIT) && (timer == TW'(1)));

  // In IDLE the live bus fields are used, which only matters for single-cycle
  // latency. Otherwise the fields captured at accept are used.
  assign addr_eff  = (state != IDLE) ? addr_q : (arvalid ? araddr : awaddr);
  assign wdata_eff = (state != IDLE) ? wdata_q : wdata;
  assign wstrb_eff = (state != IDLE) ? wstrb_q : wstrb;

  // The range check is 33 bits wide, so an address near 2^32 cannot wrap into range.
  assign offset      = addr_eff - BASE;
  assign in_range    = ({1'b0, addr_eff} >= {1'b0, BASE}) && ({1'b0, addr_eff} < LIMIT);
  assign idx         = offset[IDX_W+1:2];
  assign unused_bits = ^{offset[31:IDX_W+2], offset[1:0]};

  always_ff @(posedge clk) begin
    if (rst && wr_fire && in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb_eff[i]) mem[idx][8*i +: 8] <= wdata_eff[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      timer   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rvalid  <= 1'b0;
      bvalid  <= 1'b0;
      rdata   <= '0;
      rresp   <= 2'b00;
      bresp   <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (rd_accept) begin
            addr_q <= araddr;
            timer  <= TW'(RD_LAT - 1);
            state  <= RD_WAIT;
          end else if (wr_accept) begin
            addr_q  <= awaddr;
            wdata_q <= wdata;
            wstrb_q <= wstrb;
            timer   <= TW'(WR_LAT - 1);
            state   <= WR_WAIT;
          end
        end
        RD_WAIT, WR_WAIT: timer <= timer - TW'(1);
        RD_RESP: begin
          if (rready) begin
            rvalid <= 1'b0;
            state  <= IDLE;
          end
        end
        WR_RESP: begin
          if (bready) begin
            bvalid <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // The response takes priority over the case above. The write side of the
      // array is updated at this same edge, so a later read sees the new data.
      if (rd_fire) begin
        rdata  <= in_range ? mem[idx] : 32'h0;
        rresp  <= in_range ? 2'b00 : 2'b11;
        rvalid <= 1'b1;
        timer  <= '0;
        state  <= RD_RESP;
      end
      if (wr_fire) begin
        bresp  <= in_range ? 2'b00 : 2'b11;
        bvalid <= 1'b1;
        timer  <= '0;
        state  <= WR_RESP;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_24110015_mem_responder.sv
module tb_ysyx_24110015_mem_responder;

  localparam logic [31:0] BASE   = 32'h8000_0000;
  localparam int          DEPTH  = 4096;
  localparam int          RD_LAT = 2;
  localparam int          WR_LAT = 2;
  localparam longint      LO     = 64'h8000_0000;
  localparam longint      HI     = LO + 4 * DEPTH;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ysyx_24110015_mem_responder #(
    .BASE(BASE), .DEPTH(DEPTH), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  // ---------------- reference model (transaction level) ----------------
  longint      cyc = 0;
  bit          started = 1'b0;
  bit          busy = 1'b0;
  bit          is_rd = 1'b0;
  longint      t_acc = 0;
  bit          exp_err = 1'b0;
  bit          exp_known = 1'b0;
  logic [31:0] exp_rdata = '0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_wdata = '0;
  logic [3:0]  m_wstrb = '0;
  logic [31:0] exp_mem [int];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit in_rng(input logic [31:0] a);
    longint x;
    x = longint'({32'b0, a});
    return (x >= LO) && (x < HI);
  endfunction

  function automatic int widx(input logic [31:0] a);
    longint x;
    x = longint'({32'b0, a});
    return int'((x - LO) >> 2);
  endfunction

  task automatic commit(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] w;
    int k;
    if (!in_rng(a)) return;
    k = widx(a);
    if (!exp_mem.exists(k) && s != 4'hF) return;
    w = exp_mem.exists(k) ? exp_mem[k] : 32'h0;
    for (int i = 0; i < 4; i++) if (s[i]) w[8*i +: 8] = d[8*i +: 8];
    exp_mem[k] = w;
  endtask

  always @(posedge clk) begin
    started <= 1'b1;
    cyc     <= cyc + 1;
    if (!rst) begin
      busy <= 1'b0;
    end else if (!busy) begin
      if (arvalid) begin
        busy    <= 1'b1;
        is_rd   <= 1'b1;
        t_acc   <= cyc;
        exp_err <= !in_rng(araddr);
        if (!in_rng(araddr)) begin
          exp_rdata <= 32'h0;
          exp_known <= 1'b1;
        end else if (exp_mem.exists(widx(araddr))) begin
          exp_rdata <= exp_mem[widx(araddr)];
          exp_known <= 1'b1;
        end else begin
          exp_known <= 1'b0;
        end
      end else if (awvalid && wvalid) begin
        busy    <= 1'b1;
        is_rd   <= 1'b0;
        t_acc   <= cyc;
        exp_err <= !in_rng(awaddr);
        m_addr  <= awaddr;
        m_wdata <= wdata;
        m_wstrb <= wstrb;
        if (WR_LAT == 1) commit(awaddr, wdata, wstrb);
      end
    end else begin
      if (!is_rd && WR_LAT > 1 && cyc == t_acc + WR_LAT - 1) commit(m_addr, m_wdata, m_wstrb);
      if (cyc >= t_acc + (is_rd ? RD_LAT : WR_LAT) && (is_rd ? rready : bready)) busy <= 1'b0;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (started) begin
      automatic bit rd_due = busy && is_rd && (cyc >= t_acc + RD_LAT);
      automatic bit wr_due = busy && !is_rd && (cyc >= t_acc + WR_LAT);
      chk("arready", arready, !busy);
      chk("awready", awready, !busy && awvalid && wvalid && !arvalid);
      chk("wready", wready, !busy && awvalid && wvalid && !arvalid);
      chk("rvalid", rvalid, rd_due);
      chk("bvalid", bvalid, wr_due);
      if (rd_due) begin
        chk("rresp", rresp, exp_err ? 2'b11 : 2'b00);
        if (exp_known) chk("rdata", rdata, exp_rdata);
      end
      if (wr_due) chk("bresp", bresp, exp_err ? 2'b11 : 2'b00);
    end
  end

  // ---------------- directed transaction tasks ----------------
  task automatic do_read(input logic [31:0] a, input int stall,
                         output logic [31:0] d, output logic [1:0] r);
    longint acc;
    int n;
    @(posedge clk); #1;
    arvalid = 1'b1; araddr = a; awvalid = 1'b0; wvalid = 1'b0; rready = 1'b0;
    n = 0;
    @(negedge clk);
    while (!arready && n < 50) begin @(negedge clk); n++; end
    if (!arready) chk("rd_accept_timeout", 32'd0, 32'd1);
    acc = cyc;
    @(posedge clk); #1;
    arvalid = 1'b0; araddr = $urandom;
    n = 0;
    @(negedge clk);
    while (!rvalid && n < 50) begin @(negedge clk); n++; end
    if (!rvalid) chk("rvalid_timeout", 32'd0, 32'd1);
    chk("rd_latency", 32'(cyc - acc), RD_LAT);
    d = rdata;
    r = rresp;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("bp_rvalid", rvalid, 1'b1);
      chk("bp_rdata", rdata, d);
      chk("bp_arready", arready, 1'b0);
    end
    @(posedge clk); #1 rready = 1'b1;
    @(posedge clk); #1 rready = 1'b0;
    @(negedge clk);
    chk("rd_idle_after", arready, 1'b1);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] r);
    longint acc;
    int n;
    @(posedge clk); #1;
    awvalid = 1'b1; wvalid = 1'b1; awaddr = a; wdata = d; wstrb = s;
    arvalid = 1'b0; bready = 1'b0;
    n = 0;
    @(negedge clk);
    while (!awready && n < 50) begin @(negedge clk); n++; end
    if (!awready) chk("wr_accept_timeout", 32'd0, 32'd1);
    acc = cyc;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; awaddr = $urandom; wdata = $urandom; wstrb = 4'($urandom);
    n = 0;
    @(negedge clk);
    while (!bvalid && n < 50) begin @(negedge clk); n++; end
    if (!bvalid) chk("bvalid_timeout", 32'd0, 32'd1);
    chk("wr_latency", 32'(cyc - acc), WR_LAT);
    r = bresp;
    @(posedge clk); #1 bready = 1'b1;
    @(posedge clk); #1 bready = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    int r;
    r = $urandom_range(0, 19);
    case (r)
      16:      return BASE + 32'(4 * DEPTH - 4);
      17:      return 32'h7FFF_FFFC;
      18:      return BASE + 32'(4 * DEPTH);
      19:      return 32'hFFFF_FFFC;
      default: return BASE + 32'(4 * r) + 32'($urandom_range(0, 3));
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    int          n;

    rst = 1'b0; arvalid = 1'b1; araddr = BASE; rready = 1'b0;
    awvalid = 1'b0; awaddr = '0; wvalid = 1'b0; wdata = '0; wstrb = '0; bready = 1'b0;

    // reset held two edges with a pending read request
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    chk("rst_rvalid", rvalid, 1'b0);
    chk("rst_bvalid", bvalid, 1'b0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_rresp", rresp, 2'b00);
    chk("rst_bresp", bresp, 2'b00);
    rst = 1'b1; arvalid = 1'b0;
    @(negedge clk);
    chk("rel_arready", arready, 1'b1);

    // known contents for the words used by the random phase
    for (int i = 0; i < 16; i++) do_write(BASE + 32'(4 * i), $urandom, 4'hF, r);
    do_write(BASE + 32'(4 * DEPTH - 4), 32'hCAFE_F00D, 4'hF, r);
    chk("last_wr_bresp", r, 2'b00);

    // full write then read back
    do_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, r);
    chk("wr10_bresp", r, 2'b00);
    do_read(32'h8000_0010, 0, d, r);
    chk("rd10_rdata", d, 32'hDEAD_BEEF);
    chk("rd10_rresp", r, 2'b00);

    // partial write, then a strobe-free no-op write
    do_write(32'h8000_0020, 32'h1122_3344, 4'hF, r);
    do_write(32'h8000_0020, 32'hAABB_CCDD, 4'b0101, r);
    chk("partial_bresp", r, 2'b00);
    do_read(32'h8000_0022, 0, d, r);
    chk("partial_rdata", d, 32'h11BB_33DD);
    do_write(32'h8000_0020, 32'hFFFF_FFFF, 4'h0, r);
    chk("nostrb_bresp", r, 2'b00);
    do_read(32'h8000_0020, 0, d, r);
    chk("nostrb_rdata", d, 32'h11BB_33DD);

    // backpressure on R
    do_read(32'h8000_0010, 5, d, r);
    chk("bp_final_rdata", d, 32'hDEAD_BEEF);

    // simultaneous read and write requests: the read goes first
    @(posedge clk); #1;
    arvalid = 1'b1; araddr = 32'h8000_0010;
    awvalid = 1'b1; wvalid = 1'b1; awaddr = 32'h8000_0030; wdata = 32'h5A5A_0001; wstrb = 4'hF;
    rready = 1'b0; bready = 1'b0;
    @(negedge clk);
    chk("sim_arready", arready, 1'b1);
    chk("sim_awready", awready, 1'b0);
    chk("sim_wready", wready, 1'b0);
    @(posedge clk); #1 arvalid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!rvalid && n < 50) begin
      chk("sim_awready_wait", awready, 1'b0);
      @(negedge clk); n++;
    end
    chk("sim_rdata", rdata, 32'hDEAD_BEEF);
    @(posedge clk); #1 rready = 1'b1;
    @(posedge clk); #1 rready = 1'b0;
    @(negedge clk);
    chk("sim_wr_after_r", awready, 1'b1);
    @(posedge clk); #1 awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!bvalid && n < 50) begin @(negedge clk); n++; end
    chk("sim_bvalid", bvalid, 1'b1);
    @(posedge clk); #1 bready = 1'b1;
    @(posedge clk); #1 bready = 1'b0;
    do_read(32'h8000_0030, 0, d, r);
    chk("sim_wr_data", d, 32'h5A5A_0001);

    // out-of-range accesses
    do_read(32'h7FFF_FFFC, 0, d, r);
    chk("oor_lo_rdata", d, 32'h0);
    chk("oor_lo_rresp", r, 2'b11);
    do_read(BASE + 32'(4 * DEPTH), 0, d, r);
    chk("oor_hi_rdata", d, 32'h0);
    chk("oor_hi_rresp", r, 2'b11);
    do_write(BASE + 32'(4 * DEPTH), 32'h0BAD_0BAD, 4'hF, r);
    chk("oor_hi_bresp", r, 2'b11);
    do_write(32'h7FFF_FFFC, 32'h0BAD_0BAD, 4'hF, r);
    chk("oor_lo_bresp", r, 2'b11);
    do_read(BASE + 32'(4 * DEPTH - 4), 0, d, r);
    chk("oor_untouched", d, 32'hCAFE_F00D);
    chk("oor_untouched_rresp", r, 2'b00);

    // randomized traffic, including occasional mid-transaction resets
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      rst     = ($urandom_range(0, 149) != 0);
      arvalid = ($urandom_range(0, 3) == 0);
      araddr  = pick();
      awvalid = ($urandom_range(0, 2) != 0);
      wvalid  = ($urandom_range(0, 2) != 0);
      awaddr  = pick();
      wdata   = $urandom;
      wstrb   = 4'($urandom);
      rready  = ($urandom_range(0, 1) == 1);
      bready  = ($urandom_range(0, 1) == 1);
    end

    @(posedge clk); #1;
    rst = 1'b1; arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0; rready = 1'b1; bready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
